// File: rtl/wb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx_fifo
// Purpose  : Wishbone-slave 8N1 UART transmitter with a 2^FIFO_PTR_WIDTH
//            entry TX FIFO and a programmable baud divider.
// Ports    : reset       - synchronous, active-low reset
//            sys_clk     - clock
//            s_wb_*      - single-cycle Wishbone slave (ack = stb)
//            uart_tx     - registered serial output, idle high
//            tx_idle     - registered, high while the transmitter is idle
// Registers: 0 TX_DATA (W), 1 STATUS (R, W1C overflow), 2 DIVIDER (RW),
//            3 reserved
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_tx_fifo #(
  parameter int          WB_ADR_WIDTH   = 2,
  parameter int          WB_DAT_WIDTH   = 32,
  parameter int          FIFO_PTR_WIDTH = 4,
  parameter logic [15:0] DIVIDER_INIT   = 16'd433
) (
  input  logic                      reset,
  input  logic                      sys_clk,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_we_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  output logic                      uart_tx,
  output logic                      tx_idle
);

  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TX_DATA = WB_ADR_WIDTH'(0);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS  = WB_ADR_WIDTH'(1);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_DIVIDER = WB_ADR_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               bit_cnt_q, bit_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [7:0]                shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      tx_idle_q, tx_idle_d;
  logic [15:0]               divider_q, divider_d;
  logic                      overflow_q, overflow_d;
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR_WIDTH:0]   count_q, count_d;
  logic [7:0]                fifo_mem [DEPTH];

  logic       wb_wr, push, push_ok, pop, fifo_empty, fifo_full;
  logic [7:0] fifo_rd_data;
  logic       unused_ok;

  assign s_wb_ack_o = s_wb_stb_i;
  assign wb_wr      = s_wb_stb_i & s_wb_we_i;
  assign push       = wb_wr && (s_wb_adr_i == ADR_TX_DATA) && s_wb_sel_i[0];
  assign fifo_empty = (count_q == '0);
  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign fifo_full  = count_q[FIFO_PTR_WIDTH];
  // Full is judged before any same-cycle pop: a push into a full FIFO is lost.
  assign push_ok    = push & ~fifo_full;
  assign fifo_rd_data = fifo_mem[rd_ptr_q];

  assign uart_tx = tx_q;
  assign tx_idle = tx_idle_q;

  assign unused_ok = &{1'b0, s_wb_dat_i[WB_DAT_WIDTH-1:16],
                       s_wb_sel_i[WB_DAT_WIDTH/8-1:2]};

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_PTR_WIDTH'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + FIFO_PTR_WIDTH'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_PTR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (FIFO_PTR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge sys_clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= s_wb_dat_i[7:0];
  end

  // ------------------------------------------------------------ registers
  always_comb begin
    overflow_d = overflow_q;
    divider_d  = divider_q;
    if (push && fifo_full) begin
      overflow_d = 1'b1;
    end else if (wb_wr && (s_wb_adr_i == ADR_STATUS) && s_wb_sel_i[0] && s_wb_dat_i[3]) begin
      overflow_d = 1'b0;
    end
    if (wb_wr && (s_wb_adr_i == ADR_DIVIDER)) begin
      if (s_wb_sel_i[0]) divider_d[7:0]  = s_wb_dat_i[7:0];
      if (s_wb_sel_i[1]) divider_d[15:8] = s_wb_dat_i[15:8];
    end
  end

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      ADR_STATUS: begin
        s_wb_dat_o[0] = fifo_empty;
        s_wb_dat_o[1] = fifo_full;
        s_wb_dat_o[2] = (state_q != S_IDLE);
        s_wb_dat_o[3] = overflow_q;
        s_wb_dat_o[8 +: FIFO_PTR_WIDTH+1] = count_q;
      end
      ADR_DIVIDER: s_wb_dat_o[15:0] = divider_q;
      default:     s_wb_dat_o = '0;
    endcase
  end

  // -------------------------------------------------------------- TX FSM
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_rd_data;
          bit_cnt_d = divider_q;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = divider_q;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = divider_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop       = 1'b1;
            shift_d   = fifo_rd_data;
            bit_cnt_d = divider_q;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is registered from the current state, so the waveform
  // trails the FSM by one cycle. tx_idle follows the same lag; IDLE with a
  // non-empty FIFO lasts only the single pop cycle and still counts as idle.
  always_comb begin
    tx_d      = !((state_q == S_START) || ((state_q == S_DATA) && !shift_q[0]));
    tx_idle_d = (state_q == S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      tx_idle_q  <= 1'b1;
      divider_q  <= DIVIDER_INIT;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_idle_q  <= tx_idle_d;
      divider_q  <= divider_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_wb_uart_tx_fifo
// Purpose  : Self-checking bench for wb_uart_tx_fifo: table-driven register
//            vectors plus directed serial-frame sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_tx_fifo;

  logic        reset;
  logic        sys_clk;
  logic [1:0]  s_wb_adr_i;
  logic [31:0] s_wb_dat_i;
  logic [31:0] s_wb_dat_o;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_we_i;
  logic        s_wb_stb_i;
  logic        s_wb_ack_o;
  logic        uart_tx;
  logic        tx_idle;

  wb_uart_tx_fifo dut (
    .reset      (reset),
    .sys_clk    (sys_clk),
    .s_wb_adr_i (s_wb_adr_i),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_sel_i (s_wb_sel_i),
    .s_wb_we_i  (s_wb_we_i),
    .s_wb_stb_i (s_wb_stb_i),
    .s_wb_ack_o (s_wb_ack_o),
    .uart_tx    (uart_tx),
    .tx_idle    (tx_idle)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_bad = 0;

  always @(negedge sys_clk) begin
    #2;
    if (s_wb_ack_o !== s_wb_stb_i) ack_bad++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] wr_bytes[$];
  logic [7:0] exp_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel;
    s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    s_wb_we_i = 1'b0; s_wb_stb_i = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] adr, input logic [31:0] exp, input string name);
    s_wb_adr_i = adr;
    #1;
    check(name, s_wb_dat_o, exp);
  endtask

  // Back-to-back TX_DATA writes on consecutive edges, one per byte.
  task automatic burst();
    foreach (wr_bytes[i]) begin
      s_wb_adr_i = 2'd0; s_wb_sel_i = 4'h1; s_wb_dat_i = {24'h0, wr_bytes[i]};
      s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
      @(posedge sys_clk); @(negedge sys_clk);
    end
    s_wb_we_i = 1'b0; s_wb_stb_i = 1'b0;
  endtask

  // Expects the line high on the sample after edge start-1 and then
  // exp_bytes as contiguous 8N1 frames from the sample after edge start.
  // Frame 0 bits with index >= sw_bit last div_b+1 cycles instead of div_a+1.
  task automatic check_tx(input int start, input int div_a, input int div_b,
                          input int sw_bit, input string name);
    int guard = 0;
    while (cyc < start - 1 && guard < 1000) begin
      @(negedge sys_clk);
      guard++;
    end
    check({name, " pre-start high"}, 32'(uart_tx), 32'd1);
    @(negedge sys_clk);
    foreach (exp_bytes[f]) begin
      int bad = 0;
      logic [9:0] fr = {1'b1, exp_bytes[f], 1'b0};
      for (int b = 0; b < 10; b++) begin
        int d = (f == 0 && b >= sw_bit) ? div_b : div_a;
        for (int c = 0; c <= d; c++) begin
          if (uart_tx !== fr[b]) bad++;
          @(negedge sys_clk);
        end
      end
      check($sformatf("%s frame %0d bad cycles", name, f), bad, 0);
    end
  endtask

  typedef struct {
    logic [1:0]  adr;
    logic        we;
    logic        stb;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[16];

  initial begin
    int e;
    int hi;
    vt[0]  = '{2'd1, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_0001, "reset status"};
    vt[1]  = '{2'd2, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_01B1, "reset divider"};
    vt[2]  = '{2'd3, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_0000, "reserved read"};
    vt[3]  = '{2'd0, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_0000, "txdata read"};
    vt[4]  = '{2'd2, 1'b1, 1'b1, 32'h1234,     4'h1, 32'h0,         "wr div sel01"};
    vt[5]  = '{2'd2, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_0134, "div after sel01"};
    vt[6]  = '{2'd2, 1'b1, 1'b1, 32'h5600,     4'h2, 32'h0,         "wr div sel10"};
    vt[7]  = '{2'd2, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_5634, "div after sel10"};
    vt[8]  = '{2'd3, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,        "wr reserved"};
    vt[9]  = '{2'd3, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_0000, "reserved after wr"};
    vt[10] = '{2'd2, 1'b1, 1'b0, 32'hABCD,     4'h3, 32'h0,         "wr div no stb"};
    vt[11] = '{2'd2, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_5634, "div unchanged"};
    vt[12] = '{2'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,        "wr status"};
    vt[13] = '{2'd1, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000_0001, "status after wr"};
    vt[14] = '{2'd2, 1'b1, 1'b1, 32'hFFFF_0003, 4'hF, 32'h0,        "wr div full"};
    vt[15] = '{2'd2, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0000_0003, "div after full"};

    reset = 1'b0; s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = '0;
    s_wb_we_i = 1'b0; s_wb_stb_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1;
    check("reset uart_tx", 32'(uart_tx), 32'd1);
    check("reset tx_idle", 32'(tx_idle), 32'd1);

    // ---- register access table
    foreach (vt[i]) begin
      s_wb_adr_i = vt[i].adr; s_wb_we_i = vt[i].we; s_wb_stb_i = vt[i].stb;
      s_wb_dat_i = vt[i].dat; s_wb_sel_i = vt[i].sel;
      #1;
      check({vt[i].name, " ack"}, 32'(s_wb_ack_o), 32'(vt[i].stb));
      if (!vt[i].we) check(vt[i].name, s_wb_dat_o, vt[i].exp);
      @(negedge sys_clk);
    end
    s_wb_we_i = 1'b0; s_wb_stb_i = 1'b0;

    // ---- single byte, divider 3
    reg_write(2'd2, 32'd3, 4'h3);
    wr_bytes = '{8'h55}; exp_bytes = '{8'h55};
    e = cyc + 1;
    fork
      begin
        burst();
        reg_read(2'd1, 32'h0000_0100, "t1 status after push");
        check("t1 tx_idle after E", 32'(tx_idle), 32'd1);
        @(negedge sys_clk);
        check("t1 tx_idle after E+1", 32'(tx_idle), 32'd1);
        @(negedge sys_clk);
        check("t1 tx_idle after E+2", 32'(tx_idle), 32'd0);
        reg_read(2'd1, 32'h0000_0005, "t1 status busy");
      end
      check_tx(e + 2, 3, 3, 99, "t1");
    join
    check("t1 tx_idle after frame", 32'(tx_idle), 32'd1);
    reg_read(2'd1, 32'h0000_0001, "t1 status end");

    // ---- back-to-back, divider 0
    reg_write(2'd2, 32'd0, 4'h3);
    wr_bytes = '{8'h01, 8'h80, 8'hFF}; exp_bytes = '{8'h01, 8'h80, 8'hFF};
    e = cyc + 1;
    fork
      burst();
      check_tx(e + 2, 0, 0, 99, "t2");
    join
    check("t2 tx_idle after frames", 32'(tx_idle), 32'd1);

    // ---- overflow, divider 100
    reg_write(2'd2, 32'd100, 4'h3);
    wr_bytes.delete(); exp_bytes.delete();
    for (int i = 0; i < 18; i++) begin
      wr_bytes.push_back(8'(8'h20 + i));
      if (i < 17) exp_bytes.push_back(8'(8'h20 + i));
    end
    e = cyc + 1;
    fork
      begin
        burst();
        reg_read(2'd1, 32'h0000_100E, "t3 status full+overflow");
        reg_write(2'd1, 32'h8, 4'h1);
        reg_read(2'd1, 32'h0000_1006, "t3 status overflow cleared");
      end
      check_tx(e + 2, 100, 100, 99, "t3");
    join
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (uart_tx !== 1'b1) hi++;
      @(negedge sys_clk);
    end
    check("t3 no 18th byte", hi, 0);
    reg_read(2'd1, 32'h0000_0001, "t3 status end");

    // ---- divider change during the third data bit
    reg_write(2'd2, 32'd7, 4'h3);
    wr_bytes = '{8'hA5}; exp_bytes = '{8'hA5};
    e = cyc + 1;
    fork
      begin
        burst();
        while (cyc < e + 27) @(negedge sys_clk);
        reg_write(2'd2, 32'd1, 4'h3);
      end
      check_tx(e + 2, 7, 1, 4, "t4");
    join
    check("t4 tx_idle after frame", 32'(tx_idle), 32'd1);

    // ---- reset mid-frame with three bytes queued
    reg_write(2'd2, 32'd3, 4'h3);
    wr_bytes = '{8'h00, 8'h11, 8'h22, 8'h33};
    e = cyc + 1;
    burst();
    while (cyc < e + 10) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    reset = 1'b1;
    check("t5 uart_tx after reset", 32'(uart_tx), 32'd1);
    check("t5 tx_idle after reset", 32'(tx_idle), 32'd1);
    reg_read(2'd1, 32'h0000_0001, "t5 status after reset");
    reg_read(2'd2, 32'h0000_01B1, "t5 divider after reset");
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b1) hi++;
    end
    check("t5 no output after reset", hi, 0);

    check("ack follows stb", ack_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
